// File: rtl/pix_uart_rx.sv
// 8N1 UART receiver feeding the pixel frame buffer write port: one-cycle
// byte strobe per good frame, framing-error strobe plus saturating error count.
module pix_uart_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int D_BITS       = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_rx,
    output logic [D_BITS-1:0] o_data,
    output logic              o_valid,
    output logic              o_busy,
    output logic              o_frame_err,
    output logic [15:0]       o_err_cnt
);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int IW   = $clog2(D_BITS) + 1;
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(D_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t            state, state_next;
    logic [1:0]        sync;
    logic              rx_s;
    logic [CW-1:0]     cnt, cnt_next;
    logic [IW-1:0]     idx, idx_next;
    logic [D_BITS-1:0] shift, shift_next;
    logic [D_BITS-1:0] data_next;
    logic              valid_next, ferr_next;
    logic [15:0]       err_cnt, err_cnt_next;

    assign rx_s      = sync[1];
    assign o_busy    = (state != IDLE);
    assign o_err_cnt = err_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync        <= 2'b11;
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            shift       <= '0;
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            err_cnt     <= '0;
        end else begin
            sync        <= {sync[0], i_rx};
            state       <= state_next;
            cnt         <= cnt_next;
            idx         <= idx_next;
            shift       <= shift_next;
            o_data      <= data_next;
            o_valid     <= valid_next;
            o_frame_err <= ferr_next;
            err_cnt     <= err_cnt_next;
        end
    end

    // Counter restarts at each decision point so every sample lands mid-bit.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        idx_next     = idx;
        shift_next   = shift;
        data_next    = o_data;
        valid_next   = 1'b0;
        ferr_next    = 1'b0;
        err_cnt_next = err_cnt;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    cnt_next   = '0;
                end
            end
            START: begin
                if (cnt == CNT_HALF) begin
                    cnt_next = '0;
                    if (!rx_s) begin
                        state_next = DATA;
                        idx_next   = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_next   = '0;
                    shift_next = {rx_s, shift[D_BITS-1:1]};
                    idx_next   = idx + IW'(1);
                    if (idx == IDX_LAST) state_next = STOP;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_next = '0;
                    if (rx_s) begin
                        data_next  = shift;
                        valid_next = 1'b1;
                        state_next = IDLE;
                    end else begin
                        ferr_next  = 1'b1;
                        if (err_cnt != 16'hFFFF) err_cnt_next = err_cnt + 16'd1;
                        state_next = BREAK;
                    end
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            // A held-low line must go high before another start can be seen.
            BREAK: begin
                if (rx_s) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end
endmodule
